hazard_scoreboard: RTL and testbench

Parametrised successor to the pipeline RAW hazard detector. It replaces the three fixed stage comparators with a per-register countdown scoreboard, so each producer can carry its own result latency. This covers ALU ops with forwarding, load-use, and variable-latency multicycle ops. It sits beside the ID stage, drives the ID/IF stall, and adds WAW protection, issue-kill and a stall performance counter.

---
 rtl/hazard_scoreboard.sv | 107 ++++++++++
 tb/tb_hazard_scoreboard.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard beside ID: RAW/WAW stall, issue-kill of the
// youngest issue, busy flag and a saturating stall-cycle counter.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 4,
    parameter int NUM_SRC    = 2,
    parameter int LAT_W      = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_id_valid,
    input  logic [NUM_SRC-1:0]            i_id_rd_en,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] i_id_rd_reg,
    input  logic                          i_id_wrt,
    input  logic [REG_ADDR_W-1:0]         i_id_dst,
    input  logic [LAT_W-1:0]              i_id_lat,
    input  logic                          i_ex_kill,
    output logic                          o_stall,
    output logic                          o_busy,
    output logic [CNT_W-1:0]              o_stall_cnt
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;
    localparam logic [CNT_W-1:0] STALL_CNT_MAX = '1;

    // Register 0 has no storage; its view in w_cnt is tied to zero.
    logic [LAT_W-1:0]      r_cnt [1:NUM_REGS-1];
    logic [REG_ADDR_W-1:0] r_last_dst;
    logic                  r_last_v;
    logic [CNT_W-1:0]      r_stall_cnt;

    logic [LAT_W-1:0]      w_cnt [NUM_REGS];
    logic [NUM_REGS-1:0]   w_pending;
    logic                  w_raw;
    logic                  w_waw;
    logic                  w_stall;
    logic                  w_issue;
    logic                  w_kill;

    always_comb begin
        w_cnt[0]     = '0;
        w_pending[0] = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            w_cnt[r]     = r_cnt[r];
            w_pending[r] = (r_cnt[r] != '0);
        end
    end

    always_comb begin
        w_raw = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i_id_rd_en[i] && w_pending[i_id_rd_reg[i*REG_ADDR_W +: REG_ADDR_W]]) begin
                w_raw = 1'b1;
            end
        end
    end

    // An older write still outstanding longer than the new one would land last.
    assign w_waw   = i_id_wrt && (i_id_dst != '0) && (w_cnt[i_id_dst] > i_id_lat);
    assign w_stall = i_id_valid && (w_raw || w_waw);
    assign w_issue = i_id_valid && !w_stall && i_id_wrt && (i_id_dst != '0);
    assign w_kill  = i_ex_kill && r_last_v;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (w_issue && (i_id_dst == REG_ADDR_W'(r))) begin
                    r_cnt[r] <= i_id_lat;
                end else if (w_kill && (r_last_dst == REG_ADDR_W'(r))) begin
                    r_cnt[r] <= '0;
                end else if (r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - 1'b1;
                end
            end
        end
    end

    // Only the issue on the immediately preceding edge is killable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_dst <= '0;
            r_last_v   <= 1'b0;
        end else if (w_issue) begin
            r_last_dst <= i_id_dst;
            r_last_v   <= 1'b1;
        end else begin
            r_last_v   <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != STALL_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_stall     = w_stall;
    assign o_busy      = |w_pending;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: instance 0 uses default parameters,
// instance 1 uses a 4-bit stall counter to reach saturation quickly.
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        id_valid  [2];
    logic [1:0]  id_rd_en  [2];
    logic [7:0]  id_rd_reg [2];
    logic        id_wrt    [2];
    logic [3:0]  id_dst    [2];
    logic [3:0]  id_lat    [2];
    logic        ex_kill   [2];
    logic        stall0, busy0, stall1, busy1;
    logic [15:0] stall_cnt0;
    logic [3:0]  stall_cnt1;

    typedef struct {
        string       tag;
        int          inst;
        logic        stall;
        logic        busy;
        logic [15:0] sc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          sc_model [2];
    int          sc_max   [2];

    hazard_scoreboard u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid[0]), .i_id_rd_en(id_rd_en[0]),
        .i_id_rd_reg(id_rd_reg[0]), .i_id_wrt(id_wrt[0]), .i_id_dst(id_dst[0]),
        .i_id_lat(id_lat[0]), .i_ex_kill(ex_kill[0]), .o_stall(stall0), .o_busy(busy0),
        .o_stall_cnt(stall_cnt0)
    );

    hazard_scoreboard #(.CNT_W(4)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid[1]), .i_id_rd_en(id_rd_en[1]),
        .i_id_rd_reg(id_rd_reg[1]), .i_id_wrt(id_wrt[1]), .i_id_dst(id_dst[1]),
        .i_id_lat(id_lat[1]), .i_ex_kill(ex_kill[1]), .o_stall(stall1), .o_busy(busy1),
        .o_stall_cnt(stall_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic idle_all();
        for (int n = 0; n < 2; n++) begin
            id_valid[n]  = 1'b0;
            id_rd_en[n]  = 2'b00;
            id_rd_reg[n] = 8'h00;
            id_wrt[n]    = 1'b0;
            id_dst[n]    = 4'h0;
            id_lat[n]    = 4'h0;
            ex_kill[n]   = 1'b0;
        end
    endtask

    task automatic push_exp(input string tag, input int inst, input logic es, input logic eb);
        exp_t e;
        e.tag   = tag;
        e.inst  = inst;
        e.stall = es;
        e.busy  = eb;
        e.sc    = 16'(sc_model[inst]);
        exp_q.push_back(e);
        if (es && sc_model[inst] < sc_max[inst]) sc_model[inst]++;
    endtask

    task automatic check_pop();
        exp_t        e;
        logic        act_stall;
        logic        act_busy;
        logic [15:0] act_sc;
        e = exp_q.pop_front();
        if (e.inst == 0) begin
            act_stall = stall0;
            act_busy  = busy0;
            act_sc    = stall_cnt0;
        end else begin
            act_stall = stall1;
            act_busy  = busy1;
            act_sc    = {12'h000, stall_cnt1};
        end
        n_checks++;
        assert (act_stall === e.stall) else begin
            n_errors++;
            $error("FAIL %s stall: got %b expected %b", e.tag, act_stall, e.stall);
        end
        n_checks++;
        assert (act_busy === e.busy) else begin
            n_errors++;
            $error("FAIL %s busy: got %b expected %b", e.tag, act_busy, e.busy);
        end
        n_checks++;
        assert (act_sc === e.sc) else begin
            n_errors++;
            $error("FAIL %s stall_cnt: got %0d expected %0d", e.tag, act_sc, e.sc);
        end
    endtask

    task automatic step(input int inst, input string tag, input logic v, input logic [1:0] en,
                        input logic [3:0] s0, input logic [3:0] s1, input logic w,
                        input logic [3:0] d, input logic [3:0] lat, input logic k,
                        input logic es, input logic eb);
        @(negedge clk);
        idle_all();
        id_valid[inst]  = v;
        id_rd_en[inst]  = en;
        id_rd_reg[inst] = {s1, s0};
        id_wrt[inst]    = w;
        id_dst[inst]    = d;
        id_lat[inst]    = lat;
        ex_kill[inst]   = k;
        push_exp(tag, inst, es, eb);
        #2;
        check_pop();
    endtask

    initial begin
        sc_model[0] = 0;
        sc_model[1] = 0;
        sc_max[0]   = 65535;
        sc_max[1]   = 15;
        idle_all();
        rst_n = 1'b0;
        #2;
        push_exp("reset0", 0, 1'b0, 1'b0);
        check_pop();
        push_exp("reset1", 1, 1'b0, 1'b0);
        check_pop();
        @(negedge clk);
        rst_n = 1'b1;

        // load-use: one bubble
        step(0, "t1_load_issue", 1, 2'b00, 0, 0, 1, 3, 1, 0, 0, 0);
        step(0, "t1_use_stall",  1, 2'b01, 3, 0, 0, 0, 0, 0, 1, 1);
        step(0, "t1_use_go",     1, 2'b01, 3, 0, 0, 0, 0, 0, 0, 0);

        // ALU with forwarding: never stalls
        step(0, "t2_alu_issue",  1, 2'b00, 0, 0, 1, 5, 0, 0, 0, 0);
        step(0, "t2_fwd_use",    1, 2'b01, 5, 0, 0, 0, 0, 0, 0, 0);

        // WAW behind a multicycle producer
        step(0, "t3_mc_issue",   1, 2'b00, 0, 0, 1, 7, 6, 0, 0, 0);
        for (int k = 0; k < 5; k++)
            step(0, "t3_waw_stall", 1, 2'b00, 0, 0, 1, 7, 1, 0, 1, 1);
        step(0, "t3_waw_issue",  1, 2'b00, 0, 0, 1, 7, 1, 0, 0, 1);
        step(0, "t3_cnt7_one",   1, 2'b01, 7, 0, 0, 0, 0, 0, 1, 1);
        step(0, "t3_drain",      0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);

        // kill of the youngest issue
        step(0, "t4_issue4",     1, 2'b00, 0, 0, 1, 4, 3, 0, 0, 0);
        step(0, "t4_kill_read",  1, 2'b01, 4, 0, 0, 0, 0, 1, 1, 1);
        step(0, "t4_after_kill", 1, 2'b01, 4, 0, 0, 0, 0, 0, 0, 0);
        // kill with no recent issue is ignored
        step(0, "t4b_issue4",    1, 2'b00, 0, 0, 1, 4, 3, 0, 0, 0);
        step(0, "t4b_idle",      0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, "t4b_kill_noop", 1, 2'b01, 4, 0, 0, 0, 0, 1, 1, 1);
        step(0, "t4b_still_pend",1, 2'b01, 4, 0, 0, 0, 0, 0, 1, 1);
        step(0, "t4b_drain",     0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        // kill concurrent with an issue to another register
        step(0, "t4c_issue6",    1, 2'b00, 0, 0, 1, 6, 2, 0, 0, 0);
        step(0, "t4c_kill_iss8", 1, 2'b00, 0, 0, 1, 8, 2, 1, 0, 1);
        step(0, "t4c_read6",     1, 2'b01, 6, 0, 0, 0, 0, 0, 0, 1);
        step(0, "t4c_read8_src1",1, 2'b10, 6, 8, 0, 0, 0, 0, 1, 1);
        step(0, "t4c_drain",     0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);

        // register 0 and disabled sources
        step(0, "t5_r0",         1, 2'b11, 0, 0, 1, 0, 15, 0, 0, 0);
        step(0, "t5_r0_idle",    0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, "t5_issue2",     1, 2'b00, 0, 0, 1, 2, 3, 0, 0, 0);
        step(0, "t5_src1_off",   1, 2'b01, 1, 2, 0, 0, 0, 0, 0, 1);
        step(0, "t5_src1_on",    1, 2'b11, 1, 2, 0, 0, 0, 0, 1, 1);
        step(0, "t5_invalid",    0, 2'b11, 1, 2, 0, 0, 0, 0, 0, 1);

        // mid-operation reset
        step(0, "t6_issue9",     1, 2'b00, 0, 0, 1, 9, 10, 0, 0, 0);
        step(0, "t6_wait_a",     0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, "t6_wait_b",     0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        idle_all();
        id_valid[0]  = 1'b1;
        id_rd_en[0]  = 2'b01;
        id_rd_reg[0] = 8'h09;
        rst_n        = 1'b0;
        sc_model[0]  = 0;
        sc_model[1]  = 0;
        push_exp("t6_in_reset", 0, 1'b0, 1'b0);
        #2;
        check_pop();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, "t6_after_rel",  1, 2'b01, 9, 0, 0, 0, 0, 0, 0, 0);

        // stall counter saturation on the 4-bit instance
        step(1, "s_issue1",      1, 2'b00, 0, 0, 1, 1, 15, 0, 0, 0);
        for (int k = 0; k < 15; k++)
            step(1, "s_stall_a",  1, 2'b01, 1, 0, 0, 0, 0, 0, 1, 1);
        step(1, "s_issue2",      1, 2'b01, 1, 0, 1, 2, 15, 0, 0, 0);
        for (int k = 0; k < 15; k++)
            step(1, "s_stall_b",  1, 2'b01, 2, 0, 0, 0, 0, 0, 1, 1);
        step(1, "s_idle",        0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
